// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the EX forwarding / load-use hazard unit:
// default widths, operand select encodings and FSM state encodings.
package fwd_hazard_unit_pkg;

  localparam int NB_REG_DEF    = 5;
  localparam int NB_MUX_FW_DEF = 2;
  localparam int NB_STATS      = 16;

  // The Execution-stage operand mux decodes these same values.
  typedef enum logic [NB_MUX_FW_DEF-1:0] {
    FROM_ID_EX  = 2'd0,
    FROM_EX_MEM = 2'd1,
    FROM_MEM_WB = 2'd2
  } fw_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Priority forwarding select for one operand: the nearest writing stage whose
// destination matches the source wins; register 0 is never forwarded.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NB_REG    = NB_REG_DEF,
  parameter int N_FW      = 2,
  parameter int NB_MUX_FW = $clog2(N_FW + 1)
) (
  input  logic [NB_REG-1:0]      i_src,
  input  logic [N_FW*NB_REG-1:0] i_fw_rd,
  input  logic [N_FW-1:0]        i_fw_wr_en,
  output logic [NB_MUX_FW-1:0]   o_sel
);

  always_comb begin
    o_sel = '0;
    // Walk from the farthest stage down so the nearest match is the last write.
    for (int j = N_FW - 1; j >= 0; j--) begin
      if (i_fw_wr_en[j] && (i_fw_rd[j*NB_REG +: NB_REG] != '0) &&
          (i_fw_rd[j*NB_REG +: NB_REG] == i_src)) begin
        o_sel = NB_MUX_FW'(j + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding for N_SRC operands over N_FW stages plus a load-use
// stall FSM inserting LD_LAT bubbles. Optional FWD_STALL_STATS_EN adds a
// saturating stall-cycle counter output.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NB_REG    = NB_REG_DEF,
  parameter int N_SRC     = 2,
  parameter int N_FW      = 2,
  parameter int NB_MUX_FW = $clog2(N_FW + 1),
  parameter int LD_LAT    = 1,
  parameter int NB_LAT    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_SRC*NB_REG-1:0]    i_ex_src,
  input  logic [N_SRC*NB_REG-1:0]    i_id_src,
  input  logic [N_SRC-1:0]           i_id_src_use,
  input  logic [N_FW*NB_REG-1:0]     i_fw_rd,
  input  logic [N_FW-1:0]            i_fw_wr_en,
  input  logic [NB_REG-1:0]          i_id_ex_rd,
  input  logic                       i_id_ex_mem_rd,
  input  logic                       i_flush,
  input  logic                       i_pipe_en,
  output logic [N_SRC*NB_MUX_FW-1:0] o_mux_fw,
  output logic                       o_stall,
  output logic                       o_bubble
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [NB_STATS-1:0]        o_stall_cycles
`endif
);

  localparam logic [NB_LAT-1:0] CNT_INIT = (LD_LAT > 1) ? NB_LAT'(LD_LAT - 2) : '0;

  genvar k;
  generate
    for (k = 0; k < N_SRC; k++) begin : g_fwd
      fwd_select #(
        .NB_REG   (NB_REG),
        .N_FW     (N_FW),
        .NB_MUX_FW(NB_MUX_FW)
      ) u_fwd_select (
        .i_src     (i_ex_src[k*NB_REG +: NB_REG]),
        .i_fw_rd   (i_fw_rd),
        .i_fw_wr_en(i_fw_wr_en),
        .o_sel     (o_mux_fw[k*NB_MUX_FW +: NB_MUX_FW])
      );
    end
  endgenerate

  logic      hazard;
  logic      stall_req;
  hz_state_e state_q, state_d;
  logic [NB_LAT-1:0] cnt_q, cnt_d;

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < N_SRC; s++) begin
      if (i_id_src_use[s] && (i_id_src[s*NB_REG +: NB_REG] == i_id_ex_rd)) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && i_id_ex_mem_rd && (i_id_ex_rd != '0);
  end

  // IDLE raises the first bubble combinationally; STALL drives from the state flop.
  assign stall_req = (state_q == ST_STALL) || hazard;
  assign o_stall   = i_pipe_en && !i_flush && stall_req;
  assign o_bubble  = i_flush || (i_pipe_en && stall_req);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (i_pipe_en) begin
      case (state_q)
        ST_IDLE: begin
          if (hazard && (LD_LAT > 1)) begin
            state_d = ST_STALL;
            cnt_d   = CNT_INIT;
          end
        end
        ST_STALL: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic [NB_STATS-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (o_stall && (stall_cycles_q != {NB_STATS{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign o_stall_cycles = stall_cycles_q;
`endif

endmodule
